mult_div_unit: RTL and testbench

- Iterative multiply/divide unit fed directly by the register file read ports (RD1 → src_a, RD2 → src_b).
- Executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Holds the 2×Data_Width result in internal HI/LO registers, which the writeback mux reads for MFHI/MFLO.
- The controller stalls the core while busy is high.

---
 rtl/mult_div_unit.sv | 191 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative signed/unsigned multiply and restoring divide with
//            internal HI/LO result registers. Optional MDU_HILO_WRITE_EN adds
//            direct HI/LO write ports (MTHI/MTLO).
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int Data_Width  = 32,
  parameter int Count_Width = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [Data_Width-1:0] src_a,
  input  logic [Data_Width-1:0] src_b,
`ifdef MDU_HILO_WRITE_EN
  input  logic                  hilo_we,
  input  logic                  hilo_sel,
  input  logic [Data_Width-1:0] hilo_wd,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [Data_Width-1:0] hi,
  output logic [Data_Width-1:0] lo
);

  localparam logic [Count_Width-1:0] c_LAST_COUNT = Count_Width'(Data_Width - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q;
  logic                      is_div_q;
  logic                      sa_q;
  logic                      sb_q;
  logic                      bzero_q;
  logic [Data_Width-1:0]     a_q;
  logic [Data_Width-1:0]     b_q;
  logic [Data_Width-1:0]     raw_a_q;
  logic [2*Data_Width-1:0]   acc_q;
  logic [Count_Width-1:0]    count_q;
  logic [Data_Width-1:0]     hi_q;
  logic [Data_Width-1:0]     lo_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      dbz_q;

  logic                      w_sa;
  logic                      w_sb;
  logic [Data_Width-1:0]     w_abs_a;
  logic [Data_Width-1:0]     w_abs_b;

  logic [Data_Width:0]       sum_d;
  logic [Data_Width:0]       rem_sh_d;
  logic [Data_Width:0]       diff_d;
  logic [2*Data_Width-1:0]   acc_d;
  logic [2*Data_Width-1:0]   prod_d;
  logic [Data_Width-1:0]     quot_d;
  logic [Data_Width-1:0]     rem_d;
  logic [Data_Width-1:0]     hi_d;
  logic [Data_Width-1:0]     lo_d;

  // op[0]=1 selects the unsigned variants, so sign flags are masked by ~op[0].
  assign w_sa    = src_a[Data_Width-1] & ~op[0];
  assign w_sb    = src_b[Data_Width-1] & ~op[0];
  assign w_abs_a = w_sa ? -src_a : src_a;
  assign w_abs_b = w_sb ? -src_b : src_b;

  // One iteration: multiply keeps {partial product, multiplier}, divide keeps
  // {remainder, dividend/quotient}; both shift one bit per cycle.
  always_comb begin
    sum_d    = {1'b0, acc_q[2*Data_Width-1:Data_Width]} + {1'b0, a_q};
    rem_sh_d = acc_q[2*Data_Width-1:Data_Width-1];
    diff_d   = rem_sh_d - {1'b0, b_q};
    acc_d    = acc_q;
    if (is_div_q) begin
      if (!diff_d[Data_Width]) begin
        acc_d = {diff_d[Data_Width-1:0], acc_q[Data_Width-2:0], 1'b1};
      end else begin
        acc_d = {rem_sh_d[Data_Width-1:0], acc_q[Data_Width-2:0], 1'b0};
      end
    end else if (acc_q[0]) begin
      acc_d = {sum_d, acc_q[Data_Width-1:1]};
    end else begin
      acc_d = {1'b0, acc_q[2*Data_Width-1:1]};
    end
  end

  always_comb begin
    prod_d = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quot_d = (sa_q ^ sb_q) ? -acc_q[Data_Width-1:0] : acc_q[Data_Width-1:0];
    rem_d  = sa_q ? -acc_q[2*Data_Width-1:Data_Width] : acc_q[2*Data_Width-1:Data_Width];
    hi_d   = prod_d[2*Data_Width-1:Data_Width];
    lo_d   = prod_d[Data_Width-1:0];
    if (is_div_q) begin
      if (bzero_q) begin
        hi_d = raw_a_q;
        lo_d = '1;
      end else begin
        hi_d = rem_d;
        lo_d = quot_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bzero_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      raw_a_q  <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
`ifdef MDU_HILO_WRITE_EN
      if (hilo_we && !busy_q) begin
        if (hilo_sel) begin
          hi_q <= hilo_wd;
        end else begin
          lo_q <= hilo_wd;
        end
      end
`endif
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
          if (start) begin
            is_div_q <= op[1];
            sa_q     <= w_sa;
            sb_q     <= w_sb;
            bzero_q  <= (src_b == '0);
            a_q      <= w_abs_a;
            b_q      <= w_abs_b;
            raw_a_q  <= src_a;
            acc_q    <= op[1] ? {{Data_Width{1'b0}}, w_abs_a}
                              : {{Data_Width{1'b0}}, w_abs_b};
            count_q  <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          if (count_q == c_LAST_COUNT) begin
            state_q <= S_FIXUP;
          end else begin
            count_q <= count_q + Count_Width'(1);
          end
        end
        S_FIXUP: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          dbz_q   <= is_div_q & bzero_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed self-checking bench for mult_div_unit with a
//            transaction-level arithmetic model and per-cycle compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam int c_DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [c_DW-1:0] src_a;
  logic [c_DW-1:0] src_b;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [c_DW-1:0] hi;
  logic [c_DW-1:0] lo;
`ifdef MDU_HILO_WRITE_EN
  logic            hilo_we  = 1'b0;
  logic            hilo_sel = 1'b0;
  logic [c_DW-1:0] hilo_wd  = '0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  mult_div_unit #(.Data_Width(c_DW), .Count_Width(6)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
`ifdef MDU_HILO_WRITE_EN
    .hilo_we     (hilo_we),
    .hilo_sel    (hilo_sel),
    .hilo_wd     (hilo_wd),
`endif
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result as {div_by_zero, hi, lo} straight from the arithmetic definitions.
  function automatic logic [64:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint     sa;
    longint     sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        p = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        p = {a % b, a / b};
      end
    endcase
    return {1'b0, p};
  endfunction

  // Latency model: accepted start when idle, result lands Data_Width+1 edges later.
  logic            m_busy = 1'b0;
  logic            m_done = 1'b0;
  logic            m_dbz  = 1'b0;
  logic [c_DW-1:0] m_hi   = '0;
  logic [c_DW-1:0] m_lo   = '0;
  logic [64:0]     m_pend = '0;
  int              m_left = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_pend <= model_res(op, src_a, src_b);
          m_left <= c_DW + 1;
          m_busy <= 1'b1;
          m_dbz  <= 1'b0;
        end
      end else begin
        if (m_left == 1) begin
          m_dbz  <= m_pend[64];
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 64'(busy), 64'(m_busy));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_dbz",  64'(div_by_zero), 64'(m_dbz));
      chk("cyc_hi",   64'(hi), 64'(m_hi));
      chk("cyc_lo",   64'(lo), 64'(m_lo));
    end
  end

  // Drives one operation from a negedge; optionally pulses a junk start mid-run.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int inj, output int edges, output int bc);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    edges = 0;
    bc    = 0;
    do begin
      @(negedge clk);
      edges++;
      start = 1'b0;
      src_a = $urandom;
      src_b = $urandom;
      if (edges == inj) begin
        start = 1'b1;
        op    = 2'b11;
        src_a = 32'h5;
        src_b = 32'h0;
      end
      if (busy === 1'b1) bc++;
    end while (done !== 1'b1 && edges < 100);
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done after %0d edges, required %0d", edges, c_DW + 2);
    end
  endtask

  task automatic run_chk(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edbz);
    int e;
    int bc;
    do_op(o, a, b, 0, e, bc);
    chk({nm, "_lat"}, 64'(e), 64'd34);
    chk({nm, "_hi"}, 64'(hi), 64'(ehi));
    chk({nm, "_lo"}, 64'(lo), 64'(elo));
    chk({nm, "_dbz"}, 64'(div_by_zero), 64'(edbz));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int e;
    int bc;
    int cnt;
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    src_a = '0;
    src_b = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, e, bc);
    chk("multu_max_lat", 64'(e), 64'd34);
    chk("multu_max_busy_cycles", 64'(bc), 64'd33);
    chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max_lo", 64'(lo), 64'h0000_0001);
    repeat (5) @(negedge clk);

    run_chk("mult_m3x7",  2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_chk("mult_m5xm6", 2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'd30, 1'b0);
    run_chk("div_m7d2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_chk("div_7dm2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_chk("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_chk("divu_zero",  2'b11, 32'h1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    run_chk("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_chk("div_m8d0",   2'b10, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
    run_chk("multu_big",  2'b01, 32'h8000_0001, 32'h3, 32'h1, 32'h8000_0003, 1'b0);

    // Start pulsed mid-run with a divide-by-zero request must be ignored.
    do_op(2'b01, 32'd6, 32'd7, 5, e, bc);
    chk("busy_start_lat", 64'(e), 64'd34);
    chk("busy_start_lo", 64'(lo), 64'd42);
    chk("busy_start_dbz", 64'(div_by_zero), 64'd0);
    repeat (3) @(negedge clk);

    // Back-to-back: second start issued during the DONE cycle.
    do_op(2'b01, 32'd3, 32'd5, 0, e, bc);
    chk("b2b_first_lo", 64'(lo), 64'd15);
    do_op(2'b01, 32'd11, 32'd13, 0, e, bc);
    chk("b2b_second_lat", 64'(e), 64'd34);
    chk("b2b_second_busy_cycles", 64'(bc), 64'd33);
    chk("b2b_second_lo", 64'(lo), 64'd143);
    repeat (3) @(negedge clk);

    // Reset mid-run aborts with no done pulse and clears hi/lo.
    start = 1'b1;
    op    = 2'b01;
    src_a = 32'h1234_5678;
    src_b = 32'h9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    rst = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    chk("midrst_no_done", 64'(cnt), 64'd0);
    run_chk("post_rst_multu", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
